// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory port, decoder handshake, decoded fields and redirect.
// master = fetch unit, slave = memory/decoder/datapath side.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] issue_count;

  modport master (
    output imem_req, imem_addr, out_valid, opcode, rs, rt, rd, funct, imm,
           pc_out, pc_plus4, issue_count,
    input  imem_ack, imem_rdata, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, opcode, rs, rt, rd, funct, imm,
           pc_out, pc_plus4, issue_count,
    output imem_ack, imem_rdata, out_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue stage: PC, req/ack fetch, IR field split, valid/ready issue,
// branch redirect with squash of stale fetches.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {START, FETCH, HOLD, DROP} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic [31:0] addr_reg;
  logic [31:0] pc_out_reg;
  logic [31:0] pc_plus4_reg;
  logic [31:0] count_reg;
  logic        req_reg;
  logic        valid_reg;
  logic [31:0] redirect_target;

  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= START;
      pc_reg       <= RESET_PC;
      ir_reg       <= 32'd0;
      addr_reg     <= RESET_PC;
      pc_out_reg   <= 32'd0;
      pc_plus4_reg <= 32'd0;
      count_reg    <= 32'd0;
      req_reg      <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        START: begin
          req_reg   <= 1'b1;
          state_reg <= FETCH;
          if (bus.redirect) begin
            pc_reg   <= redirect_target;
            addr_reg <= redirect_target;
          end else begin
            addr_reg <= pc_reg;
          end
        end
        FETCH: begin
          if (bus.redirect && bus.imem_ack) begin
            // Returned word is stale; reissue at the target straight away.
            pc_reg   <= redirect_target;
            addr_reg <= redirect_target;
          end else if (bus.redirect) begin
            pc_reg    <= redirect_target;
            state_reg <= DROP;
          end else if (bus.imem_ack) begin
            ir_reg       <= bus.imem_rdata;
            pc_out_reg   <= pc_reg;
            pc_plus4_reg <= pc_reg + 32'd4;
            valid_reg    <= 1'b1;
            req_reg      <= 1'b0;
            state_reg    <= HOLD;
          end
        end
        DROP: begin
          // Outstanding request stays untouched until its ack; only pc tracks redirects.
          if (bus.redirect) pc_reg <= redirect_target;
          if (bus.imem_ack) begin
            addr_reg  <= bus.redirect ? redirect_target : pc_reg;
            state_reg <= FETCH;
          end
        end
        HOLD: begin
          if (bus.redirect) begin
            pc_reg    <= redirect_target;
            addr_reg  <= redirect_target;
            valid_reg <= 1'b0;
            req_reg   <= 1'b1;
            state_reg <= FETCH;
          end else if (bus.out_ready) begin
            pc_reg    <= pc_reg + 32'd4;
            addr_reg  <= pc_reg + 32'd4;
            count_reg <= count_reg + 32'd1;
            valid_reg <= 1'b0;
            req_reg   <= 1'b1;
            state_reg <= FETCH;
          end
        end
        default: state_reg <= START;
      endcase
    end
  end

  assign bus.imem_req    = req_reg;
  assign bus.imem_addr   = addr_reg;
  assign bus.out_valid   = valid_reg;
  assign bus.opcode      = ir_reg[31:26];
  assign bus.rs          = ir_reg[25:21];
  assign bus.rt          = ir_reg[20:16];
  assign bus.rd          = ir_reg[15:11];
  assign bus.funct       = ir_reg[5:0];
  assign bus.imm         = ir_reg[15:0];
  assign bus.pc_out      = pc_out_reg;
  assign bus.pc_plus4    = pc_plus4_reg;
  assign bus.issue_count = count_reg;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus reset-start and
// mid-fetch reset sequences.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_word;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic redirect, logic [31:0] rpc, logic ack, logic [31:0] rdata,
                              logic ready, logic e_req, logic [31:0] e_addr, logic e_valid,
                              logic [31:0] e_word, logic [31:0] e_pc, logic [31:0] e_cnt);
    vec_t v;
    v.redirect = redirect; v.rpc = rpc; v.ack = ack; v.rdata = rdata; v.ready = ready;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_word = e_word;
    v.e_pc = e_pc; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic redirect, logic [31:0] rpc, logic ack, logic [31:0] rdata, logic ready);
    bus.redirect    = redirect;
    bus.redirect_pc = rpc;
    bus.imem_ack    = ack;
    bus.imem_rdata  = rdata;
    bus.out_ready   = ready;
  endtask

  initial begin
    logic [31:0] w;
    bit got_req;
    drive(1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // Stimulus rows: inputs for one cycle, then outputs expected after that edge.
    //                rd rpc            ack rdata           rdy  req addr          v  word            pc             cnt
    vecs.push_back(mk(0, 32'h0,         1, 32'h8C43_0004, 0,   0, 32'h0,         1, 32'h8C43_0004, 32'h0000_0100, 0));
    vecs.push_back(mk(0, 32'h0,         0, 32'h0,         1,   1, 32'h0000_0104, 0, 32'h0,         32'h0,         1));
    vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0,   1, 32'h0000_0104, 0, 32'h0,         32'h0,         1));
    vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0,   1, 32'h0000_0104, 0, 32'h0,         32'h0,         1));
    vecs.push_back(mk(0, 32'h0,         1, 32'h012A_4020, 0,   0, 32'h0,         1, 32'h012A_4020, 32'h0000_0104, 1));
    vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         1, 32'h012A_4020, 32'h0000_0104, 1));
    vecs.push_back(mk(0, 32'h0,         1, 32'hFFFF_FFFF, 0,   0, 32'h0,         1, 32'h012A_4020, 32'h0000_0104, 1));
    vecs.push_back(mk(0, 32'h0,         1, 32'hFFFF_FFFF, 0,   0, 32'h0,         1, 32'h012A_4020, 32'h0000_0104, 1));
    vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         1, 32'h012A_4020, 32'h0000_0104, 1));
    vecs.push_back(mk(0, 32'h0,         0, 32'h0,         1,   1, 32'h0000_0108, 0, 32'h0,         32'h0,         2));
    // redirect in FETCH, ack two cycles later: stale word dropped
    vecs.push_back(mk(1, 32'h0000_0203, 0, 32'h0,         0,   1, 32'h0000_0108, 0, 32'h0,         32'h0,         2));
    vecs.push_back(mk(0, 32'h0,         0, 32'h0,         0,   1, 32'h0000_0108, 0, 32'h0,         32'h0,         2));
    vecs.push_back(mk(0, 32'h0,         1, 32'hFFFF_FFFF, 0,   1, 32'h0000_0200, 0, 32'h0,         32'h0,         2));
    vecs.push_back(mk(0, 32'h0,         1, 32'h3C01_1234, 0,   0, 32'h0,         1, 32'h3C01_1234, 32'h0000_0200, 2));
    // redirect together with out_ready in HOLD: squashed, no count
    vecs.push_back(mk(1, 32'h0000_0300, 0, 32'h0,         1,   1, 32'h0000_0300, 0, 32'h0,         32'h0,         2));
    // redirect together with ack in FETCH
    vecs.push_back(mk(1, 32'h0000_0407, 1, 32'hDEAD_BEEF, 0,   1, 32'h0000_0404, 0, 32'h0,         32'h0,         2));
    // two redirects while DROP waits on its ack
    vecs.push_back(mk(1, 32'h0000_0040, 0, 32'h0,         0,   1, 32'h0000_0404, 0, 32'h0,         32'h0,         2));
    vecs.push_back(mk(1, 32'h0000_0080, 0, 32'h0,         0,   1, 32'h0000_0404, 0, 32'h0,         32'h0,         2));
    vecs.push_back(mk(0, 32'h0,         1, 32'hDEAD_BEEF, 0,   1, 32'h0000_0080, 0, 32'h0,         32'h0,         2));
    vecs.push_back(mk(0, 32'h0,         1, 32'h8C43_0004, 0,   0, 32'h0,         1, 32'h8C43_0004, 32'h0000_0080, 2));
    vecs.push_back(mk(1, 32'h0000_0500, 0, 32'h0,         0,   1, 32'h0000_0500, 0, 32'h0,         32'h0,         2));
    // redirect coinciding with the DROP ack still wins
    vecs.push_back(mk(1, 32'h0000_0600, 0, 32'h0,         0,   1, 32'h0000_0500, 0, 32'h0,         32'h0,         2));
    vecs.push_back(mk(1, 32'h0000_0700, 1, 32'hDEAD_BEEF, 0,   1, 32'h0000_0700, 0, 32'h0,         32'h0,         2));
    vecs.push_back(mk(0, 32'h0,         1, 32'h8C43_0004, 0,   0, 32'h0,         1, 32'h8C43_0004, 32'h0000_0700, 2));
    vecs.push_back(mk(0, 32'h0,         0, 32'h0,         1,   1, 32'h0000_0704, 0, 32'h0,         32'h0,         3));
    // PC wrap at the top of the address space
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 32'h0,         0,   1, 32'h0000_0704, 0, 32'h0,         32'h0,         3));
    vecs.push_back(mk(0, 32'h0,         1, 32'hDEAD_BEEF, 0,   1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         3));
    vecs.push_back(mk(0, 32'h0,         1, 32'h012A_4020, 0,   0, 32'h0,         1, 32'h012A_4020, 32'hFFFF_FFFC, 3));
    vecs.push_back(mk(0, 32'h0,         0, 32'h0,         1,   1, 32'h0000_0000, 0, 32'h0,         32'h0,         4));

    // Reset state, with a straggler ack held high throughout.
    repeat (3) tick();
    chk("rst_req",    {31'd0, bus.imem_req},  32'd0);
    chk("rst_addr",   bus.imem_addr,          32'h0000_0100);
    chk("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
    chk("rst_opcode", {26'd0, bus.opcode},    32'd0);
    chk("rst_imm",    {16'd0, bus.imm},       32'd0);
    chk("rst_count",  bus.issue_count,        32'd0);
    $display("reset: req=%0d addr=%08h valid=%0d count=%0d", bus.imem_req, bus.imem_addr,
             bus.out_valid, bus.issue_count);

    rst_n = 1'b1;
    chk("start_req", {31'd0, bus.imem_req}, 32'd0);
    got_req = 1'b0;
    for (int c = 0; c < 4 && !got_req; c++) begin
      tick();
      got_req = bus.imem_req;
    end
    chk("first_req", {31'd0, bus.imem_req},  32'd1);
    chk("first_addr", bus.imem_addr,         32'h0000_0100);
    chk("first_valid", {31'd0, bus.out_valid}, 32'd0);
    $display("start: req=%0d addr=%08h", bus.imem_req, bus.imem_addr);
    if (!got_req) begin
      $display("FAIL start_timeout: got no imem_req expected imem_req within 4 cycles");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "no fetch request after reset");
    end

    foreach (vecs[i]) begin
      drive(vecs[i].redirect, vecs[i].rpc, vecs[i].ack, vecs[i].rdata, vecs[i].ready);
      tick();
      chk($sformatf("row%0d_req", i),   {31'd0, bus.imem_req},  {31'd0, vecs[i].e_req});
      chk($sformatf("row%0d_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("row%0d_count", i), bus.issue_count,        vecs[i].e_cnt);
      if (vecs[i].e_req) chk($sformatf("row%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
      if (vecs[i].e_valid) begin
        w = vecs[i].e_word;
        chk($sformatf("row%0d_opcode", i), {26'd0, bus.opcode}, {26'd0, w[31:26]});
        chk($sformatf("row%0d_rs", i),     {27'd0, bus.rs},     {27'd0, w[25:21]});
        chk($sformatf("row%0d_rt", i),     {27'd0, bus.rt},     {27'd0, w[20:16]});
        chk($sformatf("row%0d_rd", i),     {27'd0, bus.rd},     {27'd0, w[15:11]});
        chk($sformatf("row%0d_funct", i),  {26'd0, bus.funct},  {26'd0, w[5:0]});
        chk($sformatf("row%0d_imm", i),    {16'd0, bus.imm},    {16'd0, w[15:0]});
        chk($sformatf("row%0d_pc", i),     bus.pc_out,          vecs[i].e_pc);
        chk($sformatf("row%0d_pc4", i),    bus.pc_plus4,        vecs[i].e_pc + 32'd4);
      end
      $display("row%0d: rd=%0d ack=%0d rdy=%0d -> req=%0d addr=%08h valid=%0d pc=%08h count=%0d",
               i, vecs[i].redirect, vecs[i].ack, vecs[i].ready, bus.imem_req, bus.imem_addr,
               bus.out_valid, bus.pc_out, bus.issue_count);
    end

    // Asynchronous reset mid-FETCH clears the request at once; late ack is ignored.
    drive(1'b0, 32'd0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_req",   {31'd0, bus.imem_req},  32'd0);
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_count", bus.issue_count,        32'd0);
    $display("async reset: req=%0d valid=%0d", bus.imem_req, bus.out_valid);
    drive(1'b0, 32'd0, 1'b1, 32'h8C43_0004, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("late_ack_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("late_ack_req",   {31'd0, bus.imem_req},  32'd1);
    chk("late_ack_addr",  bus.imem_addr,          32'h0000_0100);
    chk("late_ack_opc",   {26'd0, bus.opcode},    32'd0);
    $display("late ack: req=%0d addr=%08h valid=%0d", bus.imem_req, bus.imem_addr, bus.out_valid);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
